// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, 1 or 2 stop bits.
// The bit timing matches uart_receiver. o_tx is registered so the line never glitches.
module uart_transmitter #(
    parameter int FULL_buad = 9,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_8_data,
    input  logic       i_send,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);
    localparam int BW = (FULL_buad < 1) ? 1 : $clog2(FULL_buad + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(FULL_buad);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_q, stop_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (state_q != IDLE) && (baud_q == BAUD_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q != IDLE)
            baud_d = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (i_send) begin
                    shreg_d = i_8_data;
                    par_d   = ^i_8_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so o_tx lines up with o_busy.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected bytes and a line
// monitor decodes each frame cycle by cycle and compares it with the queued byte.
module tb_uart_transmitter;
    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       send;
    logic       tx, busy, done;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nfail = 0;
    int   done_seen = 0;
    int   exp_done = 0;
    logic was_done;

    uart_transmitter #(.FULL_buad(9), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_8_data(data), .i_send(send),
        .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Waits for IDLE (bounded), then issues one send and checks the start-bit latency.
    task automatic send_byte(input logic [7:0] d, input logic p);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("send_wait_timeout", 1, 0);
        was_done = done;
        data = d;
        send = 1'b1;
        e.d = d;
        e.p = p;
        q.push_back(e);
        exp_done++;
        @(negedge clk);
        send = 1'b0;
        chk("start_latency", {30'd0, tx, busy}, 32'b01);
    endtask

    always @(negedge clk) if (rst_n && done) done_seen++;

    // Line monitor: one comparison per bit (level held steady for all 10 clocks).
    initial begin
        exp_t e;
        logic [10:0] bits;
        logic lvl, stab, ab;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                chk("frame_expected", {31'd0, q.size() > 0}, 1);
                if (q.size() > 0) e = q.pop_front();
                else begin e.d = 8'h00; e.p = 1'b0; end
                bits = {1'b1, e.p, e.d, 1'b0};
                chk("busy_in_frame", {31'd0, busy}, 1);
                ab = 1'b0;
                lvl = 1'b0;
                stab = 1'b1;
                for (int k = 0; k < 110 && !ab; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    else begin
                        if (k % 10 == 0) begin
                            lvl = tx;
                            stab = 1'b1;
                        end else if (tx !== lvl) stab = 1'b0;
                        if (k % 10 == 9)
                            chk($sformatf("frame_%02h_bit%0d", e.d, k / 10),
                                {30'd0, stab, lvl}, {30'd0, 1'b1, bits[k/10]});
                    end
                end
                if (!ab) begin
                    @(negedge clk);
                    chk($sformatf("done_after_frame_%02h", e.d), {30'd0, done, busy}, 32'b10);
                end else begin
                    while (!rst_n) @(negedge clk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        send = 1'b1;
        data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {29'd0, tx, busy, done}, 32'b100);
        end
        send = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, tx, busy}, 32'b10);

        send_byte(8'h55, 1'b0);
        send_byte(8'h07, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'hA3, 1'b0);

        // Mid-frame send is ignored; the next send lands on the o_done cycle.
        send_byte(8'h80, 1'b1);
        repeat (30) @(negedge clk);
        data = 8'h12;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data = 8'hEE;
        send_byte(8'h34, 1'b1);
        chk("back_to_back_on_done", {31'd0, was_done}, 1);

        // Abort during data bit 4 (frame cycles 50..59).
        send_byte(8'hFF, 1'b0);
        repeat (54) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_done--;
        #1;
        chk("abort_immediate", {29'd0, tx, busy, done}, 32'b100);
        repeat (2) @(negedge clk);
        chk("abort_held", {29'd0, tx, busy, done}, 32'b100);
        rst_n = 1'b1;

        send_byte(8'hC5, 1'b0);
        t = 0;
        @(negedge clk);
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("final_idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_pulse_count", done_seen, exp_done);
        chk("line_idle_high", {31'd0, tx}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
